fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Consumer end of the next-PC selection path. Holds the architectural PC, fetches from instruction memory over a req/gnt/rvalid handshake, and presents instructions to the IF/ID stage with a valid/ready handshake.
- Feeds PC+4 back to the next-PC mux and accepts branch/jump redirects from it.
- Sits between the next-PC mux, the instruction memory port, and the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; all PC arithmetic is modulo 2^ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDR_W  target PC, qualified by redirect_valid.
- pcplus4  output  ADDR_W  current PC+4, combinational, to the next-PC mux.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_W  fetch address, equal to the current PC.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  instruction slot full.
- if_pc  output  ADDR_W  PC of the slot instruction.
- if_pcplus4  output  ADDR_W  if_pc+4.
- if_instr  output  32  instruction word.
- id_ready  input  1  decode consumes the slot when if_valid & id_ready.
- fetch_misalign  output  1  optional; see Optional Feature.

Behaviour:
- Reset values: pc=RESET_PC, state=REQ, kill=0, if_valid=0, if_pc=0, if_instr=0, fetch_misalign=0.
- slot_free = !if_valid | id_ready.
- imem_req = (state==REQ) & slot_free & !halted. Combinational.
- FSM, REQ state:
  - If imem_req & imem_gnt, go to WAIT.
  - imem_rvalid is ignored in REQ. This covers stray responses after a mid-operation reset.
- FSM, WAIT state:
  - On imem_rvalid with kill=0: load the slot (if_valid=1, if_pc=pc, if_instr=imem_rdata), set pc<=pc+4, go to REQ.
  - On imem_rvalid with kill=1: discard the data, clear kill, go to REQ. pc is unchanged.
- At most one request is outstanding. The slot is guaranteed empty when rvalid arrives, because a request is issued only when slot_free.
- Consuming the slot with no new load clears if_valid.
- Peak throughput: 1 instruction per 2 cycles, with gnt and rvalid each arriving in the cycle after the previous step.
- imem_addr stays stable while imem_req is high and ungranted. The only exception is a redirect.
- Redirect has top priority. On the same edge:
  - pc<=redirect_pc and if_valid<=0 (the slot is flushed even if id_ready is high).
  - In REQ without gnt: stay in REQ; the request is re-presented with the new address.
  - In REQ with gnt: go to WAIT with kill=1.
  - In WAIT without rvalid: set kill=1.
  - In WAIT with rvalid: discard the data and go to REQ.
- pc+4 wraps: 32'hFFFF_FFFC becomes 32'h0000_0000.
- Reset mid-operation returns all state to reset values on that edge. A later response for the aborted request is ignored.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 and halted=1.
  - pc still loads redirect_pc, and no requests are issued while halted. Any outstanding response is still drained via kill.
  - The next aligned redirect clears both fetch_misalign and halted.
- Undefined:
  - fetch_misalign is tied to 0 and halted is constant 0.
  - Misaligned targets are fetched as given.

Decomposition:
- Shared package cpu_pkg holds:
  - The fetch state enum {REQ, WAIT}.
  - The RESET_PC default constant.
  - The PC increment constant 4.
- No sub-module; the FSM, PC register and slot register form one block.

Test Plan:
- Reset then 0-cycle gnt and 1-cycle rvalid, with id_ready=1 -> imem_addr sequence 3000, 3004, 3008, and if_pc follows with if_instr matching each rdata.
- Hold id_ready=0 for 5 cycles after the first fetch -> if_valid and if_instr stay constant, imem_req=0, and no second request is issued until id_ready=1.
- Redirect to 32'h0000_4000 while in WAIT, then rvalid 3 cycles later with 32'hDEAD_BEEF -> the data is discarded, the next imem_addr is 4000, and if_valid never shows BEEF.
- Redirect to 4000 in the same cycle as gnt for 3008 -> kill is set, the 3008 response is dropped, and the next request goes to 4000.
- Redirect to 32'hFFFF_FFFC -> fetch there, then the next imem_addr is 32'h0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 32'h0000_4002 -> fetch_misalign=1 and imem_req=0. A subsequent redirect to 4000 clears fetch_misalign and resumes fetching.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: fetch FSM state encoding, reset PC default
// and the sequential PC increment.
package cpu_pkg;

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned PC_INCR          = 4;

endpackage

// File: rtl/fetch_pc_unit.sv
// Architectural PC, single-outstanding instruction fetch and the IF/ID slot.
// Optional macro FETCH_ALIGN_CHECK_EN halts fetch after a misaligned redirect.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   pcplus4,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [ADDR_W-1:0]   if_pcplus4,
    output logic [31:0]         if_instr,
    input  logic                id_ready,
    output logic                fetch_misalign
);

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_kill;
    logic               r_if_valid;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [31:0]        r_if_instr;

    logic               w_halted;
    logic               w_slot_free;
    logic               w_req;
    logic               w_grant;
    logic               w_load;
    logic               w_consume;
    logic [ADDR_W-1:0]  w_pcplus4;

    assign w_pcplus4   = r_pc + ADDR_W'(PC_INCR);
    assign w_slot_free = !r_if_valid || id_ready;
    assign w_req       = (r_state == REQ) && w_slot_free && !w_halted;
    assign w_grant     = w_req && imem_gnt;
    assign w_consume   = r_if_valid && id_ready;
    // A redirect on the response edge makes the returning word stale as well.
    assign w_load      = (r_state == WAIT) && imem_rvalid && !r_kill && !redirect_valid;

    assign pcplus4     = w_pcplus4;
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_pcplus4  = r_if_pc + ADDR_W'(PC_INCR);
    assign if_instr    = r_if_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            if (redirect_valid) begin
                r_if_valid <= 1'b0;
            end else if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_instr <= imem_rdata;
            end else if (w_consume) begin
                r_if_valid <= 1'b0;
            end

            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_load) begin
                r_pc <= w_pcplus4;
            end

            // Responses arriving in REQ belong to an aborted request and are ignored.
            if (r_state == REQ) begin
                if (w_grant) begin
                    r_state <= WAIT;
                    r_kill  <= redirect_valid;
                end
            end else begin
                if (imem_rvalid) begin
                    r_state <= REQ;
                    r_kill  <= 1'b0;
                end else if (redirect_valid) begin
                    r_kill  <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= |redirect_pc[1:0];
        end
    end

    assign w_halted       = r_halted;
    assign fetch_misalign = r_halted;
`else
    assign w_halted       = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized checks of fetch_pc_unit against a transaction-level
// model of the fetch slot, the outstanding request and the architectural PC.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pcplus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
    logic [31:0] if_instr;
    logic        id_ready = 1'b0;
    logic        fetch_misalign;

    int checks   = 0;
    int failures = 0;

    // Model: architectural PC, one in-flight fetch (possibly stale), the slot.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_stale;
    bit          m_sv;
    logic [31:0] m_spc;
    logic [31:0] m_sinstr;
    bit          m_halt;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pcplus4        (pcplus4),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pcplus4     (if_pcplus4),
        .if_instr       (if_instr),
        .id_ready       (id_ready),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0000_3000;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_sv     = 1'b0;
        m_spc    = '0;
        m_sinstr = '0;
        m_halt   = 1'b0;
    endtask

    function automatic bit model_req(input bit rdy);
        return !m_out && (!m_sv || rdy) && !m_halt;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                        input bit g, input bit rv, input logic [31:0] rd, input bit rdy);
        bit req;
        bit consumed;
        bit granted;
        bit resp;
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        id_ready       = rdy;
        #1;
        req = model_req(rdy);
        check("imem_req",       {31'b0, imem_req},       {31'b0, req});
        check("imem_addr",      imem_addr,               m_pc);
        check("pcplus4",        pcplus4,                 m_pc + 32'd4);
        check("if_valid",       {31'b0, if_valid},       {31'b0, m_sv});
        check("if_pc",          if_pc,                   m_spc);
        check("if_pcplus4",     if_pcplus4,              m_spc + 32'd4);
        check("if_instr",       if_instr,                m_sinstr);
        check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_halt});
        consumed = m_sv && rdy;
        granted  = req && g;
        resp     = m_out && rv;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (consumed) m_sv = 1'b0;
            if (resp) begin
                m_out = 1'b0;
                if (!m_stale && !redir) begin
                    m_sv     = 1'b1;
                    m_spc    = m_pc;
                    m_sinstr = rd;
                    m_pc     = m_pc + 32'd4;
                    $display("fetch   pc=%h instr=%h", m_spc, m_sinstr);
                end
                m_stale = 1'b0;
            end
            if (granted) begin
                m_out   = 1'b1;
                m_stale = 1'b0;
            end
            if (redir) begin
                $display("redirect pc=%h", rpc);
                m_pc = rpc;
                m_sv = 1'b0;
                if (m_out) m_stale = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                m_halt = (rpc[1:0] != 2'b00);
`endif
            end
        end
        #1;
    endtask

    bit          t_rdy;
    bit          t_redir;
    bit          t_g;
    bit          t_rv;
    bit          t_r;
    logic [31:0] t_rpc;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Back-to-back fetch 3000, 3004, 3008 with immediate gnt and 1-cycle rvalid.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, '0, 1, 0, '0, 1);
            step(0, 0, '0, 0, 1, 32'h0000_1013 + 32'(k), 1);
        end

        // Decode stalls: slot holds, no new request even with gnt offered.
        for (int k = 0; k < 5; k++) step(0, 0, '0, 1, 0, '0, 0);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'h0000_2093, 1);

        // Redirect while waiting; late response must be dropped.
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 1, 32'h0000_4000, 0, 0, '0, 1);
        step(0, 0, '0, 0, 0, '0, 1);
        step(0, 0, '0, 0, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'hDEAD_BEEF, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'h0000_3013, 1);

        // Redirect coinciding with gnt for 3008.
        step(0, 1, 32'h0000_3008, 0, 0, '0, 1);
        step(0, 1, 32'h0000_4000, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'hBAD0_3008, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'h0000_4013, 1);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 0, 0, '0, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'h0000_5013, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'h0000_6013, 1);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect halts fetch until an aligned one arrives.
        step(0, 1, 32'h0000_4002, 0, 0, '0, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 1, 32'h0000_4000, 0, 0, '0, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'h0000_7013, 1);
`endif

        // Reset while a request is outstanding; the stray response is ignored.
        step(0, 0, '0, 1, 0, '0, 1);
        step(1, 0, '0, 0, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'hCAFE_F00D, 1);
        step(0, 0, '0, 1, 0, '0, 1);
        step(0, 0, '0, 0, 1, 32'h0000_8013, 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            t_rdy   = ($urandom_range(0, 9) < 7);
            t_redir = ($urandom_range(0, 19) == 0);
            t_rpc   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) t_rpc[1:0] = 2'($urandom_range(1, 3));
            t_g     = model_req(t_rdy) && ($urandom_range(0, 9) < 6);
            t_rv    = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
            t_r     = ($urandom_range(0, 199) == 0);
            step(t_r, t_redir, t_rpc, t_g, t_rv, $urandom, t_rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
